// File: rtl/inst_encoder.sv
// Instruction encoder: packs decoded field bundles into 32-bit instruction
// words and streams the legal ones into instruction memory. Illegal
// bundles are dropped and counted.
module inst_encoder #(
    parameter int XLEN = 32,
    parameter int AW   = 10,
    parameter int CW   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [CW-1:0]   len,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_opc,
    input  logic [4:0]      in_ra,
    input  logic [4:0]      in_rb,
    input  logic [4:0]      in_rd,
    input  logic [10:0]     in_imd,
    output logic            imem_we,
    output logic [AW-1:0]   imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]   ptr_q;
    logic [CW-1:0]   rem_q;
    logic            imem_we_q;
    logic [AW-1:0]   imem_addr_q;
    logic [XLEN-1:0] imem_wdata_q;
    logic            err_q;
    logic [7:0]      err_cnt_q;

    logic [XLEN-1:0] enc_word;
    logic            legal;
    logic            accept;

    assign enc_word = {in_opc, in_ra, in_rb, in_rd, in_imd};
    assign accept   = in_valid && in_ready;

    // Opcode legality: the base block 0x00-0x0E, the byte load/store pair,
    // and CTRL only for its four defined branch kinds.
    always_comb begin
        legal = 1'b0;
        if (in_opc <= 6'h0E) begin
            legal = !((in_opc == 6'h0D) && (in_rd > 5'd3));
        end else if ((in_opc == 6'h2B) || (in_opc == 6'h2C)) begin
            legal = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status outputs; abort overrides any acceptance.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                in_ready = !abort;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept && legal && (rem_q == CW'(1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = !abort;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Load bookkeeping, write port and error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            rem_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            imem_we_q <= 1'b0;
            if ((state_q == S_IDLE) && start) begin
                ptr_q     <= base_addr;
                rem_q     <= len;
                err_q     <= 1'b0;
                err_cnt_q <= '0;
            end else if (accept) begin
                if (legal) begin
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= ptr_q;
                    imem_wdata_q <= enc_word;
                    ptr_q        <= ptr_q + AW'(1);
                    rem_q        <= rem_q - CW'(1);
                end else begin
                    err_q <= 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: random and directed loads checked against a
// queue-based reference model of the expected memory writes.
module tb_inst_encoder;

    localparam int AW = 10;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    in_opc = '0;
    logic [4:0]    in_ra = '0;
    logic [4:0]    in_rb = '0;
    logic [4:0]    in_rd = '0;
    logic [10:0]   in_imd = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    err_cnt;

    inst_encoder #(.XLEN(32), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .len(len), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_opc(in_opc), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
        .in_imd(in_imd), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed writes and done pulses.
    int unsigned wr_addr_q[$];
    int unsigned wr_data_q[$];
    int          done_cnt = 0;

    // Reference model state.
    int unsigned exp_addr[$];
    int unsigned exp_data[$];
    int unsigned m_ptr, m_rem, m_cnt;
    bit          m_err;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
        if (done === 1'b1) done_cnt++;
    end

    function automatic bit is_legal(input int unsigned opc, input int unsigned rd);
        if (opc == 'h0D) return rd <= 3;
        return (opc <= 'h0E) || (opc == 'h2B) || (opc == 'h2C);
    endfunction

    function automatic int unsigned pick_legal_opc();
        int unsigned v = $urandom_range(0, 16);
        if (v == 15) return 'h2B;
        if (v == 16) return 'h2C;
        return v;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete(); wr_data_q.delete(); done_cnt = 0;
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic start_load(input int unsigned b, input int unsigned l);
        @(negedge clk);
        start = 1'b1; base_addr = AW'(b); len = CW'(l);
        m_ptr = b; m_rem = l; m_err = 0; m_cnt = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one bundle for one cycle; rdy is in_ready seen during it.
    task automatic send(input int unsigned opc, input int unsigned ra, input int unsigned rb,
                        input int unsigned rd, input int unsigned imd, input bit valid,
                        output logic rdy);
        in_valid = valid; in_opc = 6'(opc); in_ra = 5'(ra); in_rb = 5'(rb);
        in_rd = 5'(rd); in_imd = 11'(imd);
        #1 rdy = in_ready;
        if (valid && m_rem > 0) begin
            if (is_legal(opc, rd)) begin
                exp_addr.push_back(m_ptr);
                exp_data.push_back(opc * 2**26 + ra * 2**21 + rb * 2**16 + rd * 2**11 + imd);
                m_ptr = (m_ptr + 1) % 2**AW;
                m_rem--;
            end else begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_rand(input bit force_legal, output logic rdy);
        int unsigned opc = ($urandom_range(0, 3) == 0 && !force_legal)
                           ? $urandom_range(0, 63) : pick_legal_opc();
        int unsigned rd = force_legal ? $urandom_range(0, 3) : $urandom_range(0, 31);
        bit valid = force_legal ? 1'b1 : ($urandom_range(0, 3) != 0);
        send(opc, $urandom_range(0, 31), $urandom_range(0, 31), rd,
             $urandom_range(0, 2047), valid, rdy);
    endtask

    task automatic finish_load();
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {in_ready, imem_we, busy, done, err});
        end
        checks++;
        if ({imem_addr, imem_wdata, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h cnt %0d want 0", imem_addr, imem_wdata, err_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic rdy;
        clear_log();
        start_load('h010, 3);
        send('h00, 1, 2, 3, 0, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", rdy); end
        repeat (2) begin
            send_rand(1'b1, rdy);
            checks++;
            if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", rdy); end
        end
        finish_load();
        checks++;
        if (wr_addr_q.size() != 3) begin
            errors++; $display("FAIL basic_count: got %0d want 3", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_data_q[0] !== 32'h00221800) begin
                errors++; $display("FAIL basic_first_word: got %h want 00221800", wr_data_q[0]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[i] !== 'h010 + i || wr_data_q[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL basic_write%0d: got %h/%h want %h/%h", i, wr_addr_q[i],
                             wr_data_q[i], 'h010 + i, exp_data[i]);
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
        checks++;
        if ({in_ready, busy} !== 2'b00 || imem_addr !== 10'h012) begin
            errors++;
            $display("FAIL basic_idle: ready %b busy %b addr %h want 0 0 012", in_ready, busy, imem_addr);
        end
        $display("test_basic: %0d writes, %0d done", wr_addr_q.size(), done_cnt);
    endtask

    task automatic test_illegal();
        logic rdy;
        int unsigned want;
        clear_log();
        start_load('h055, 1);
        send('h0D, 1, 1, 4, 0, 1'b1, rdy);
        send('h0F, 1, 1, 1, 0, 1'b1, rdy);
        send('h2B, 3, 5, 7, 'h123, 1'b1, rdy);
        finish_load();
        want = 32'hAC000000 | (3 << 21) | (5 << 16) | (7 << 11) | 'h123;
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd2) begin
            errors++; $display("FAIL illegal_err: got err %b cnt %0d want 1 2", err, err_cnt);
        end
        checks++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== want || wr_addr_q[0] !== 'h055) begin
            errors++;
            $display("FAIL illegal_write: got %0d writes first %h want 1 write %h", wr_data_q.size(),
                     (wr_data_q.size() > 0) ? wr_data_q[0] : 0, want);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL illegal_done: got %0d want 1", done_cnt); end
        $display("test_illegal: err_cnt %0d, %0d writes", err_cnt, wr_data_q.size());
    endtask

    task automatic test_wrap();
        logic rdy;
        int unsigned want_addr[3] = '{'h3FE, 'h3FF, 'h000};
        clear_log();
        start_load('h3FE, 3);
        repeat (3) send_rand(1'b1, rdy);
        finish_load();
        checks++;
        if (wr_addr_q.size() != 3) begin
            errors++; $display("FAIL wrap_count: got %0d want 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[i] !== want_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL wrap_write%0d: got %h/%h want %h/%h", i, wr_addr_q[i],
                             wr_data_q[i], want_addr[i], exp_data[i]);
                end
            end
        end
        $display("test_wrap: %0d writes", wr_addr_q.size());
    endtask

    task automatic test_len_zero();
        clear_log();
        @(negedge clk);
        start = 1'b1; len = '0; base_addr = 10'h123;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({busy, done, in_ready} !== 3'b110) begin
            errors++; $display("FAIL len0_done_cycle: got %b want 110", {busy, done, in_ready});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL len0_idle: got %b want 00", {busy, done});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL len0_outcome: got %0d writes %0d done want 0 1", wr_addr_q.size(), done_cnt);
        end
        $display("test_len_zero: %0d done", done_cnt);
    endtask

    task automatic test_abort();
        logic rdy;
        clear_log();
        start_load('h100, 4);
        send('h01, 2, 3, 4, 5, 1'b1, rdy);
        abort = 1'b1; in_valid = 1'b1; in_opc = 6'h02; in_rd = 5'd1;
        #1;
        checks++;
        if ({in_ready, busy} !== 2'b01) begin
            errors++; $display("FAIL abort_ready: got %b want 01", {in_ready, busy});
        end
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b want 0", busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 1 || done_cnt != 0 || wr_data_q[0] !== exp_data[0]) begin
            errors++;
            $display("FAIL abort_outcome: got %0d writes %0d done want 1 0", wr_addr_q.size(), done_cnt);
        end
        clear_log();
        start_load('h200, 1);
        send_rand(1'b1, rdy);
        finish_load();
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 'h200 || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart: got %0d writes %0d done want 1 1", wr_addr_q.size(), done_cnt);
        end
        $display("test_abort: restart wrote %0d", wr_addr_q.size());
    endtask

    task automatic test_random();
        logic rdy;
        for (int n = 0; n < 5; n++) begin
            int guard = 0;
            clear_log();
            start_load($urandom_range(0, 1023), $urandom_range(1, 6));
            while (m_rem > 0 && guard < 200) begin
                send_rand(1'b0, rdy);
                guard++;
                checks++;
                if (rdy !== 1'b1) begin errors++; $display("FAIL rand_ready: got %b want 1", rdy); end
            end
            finish_load();
            checks++;
            if (wr_addr_q.size() != exp_addr.size() || done_cnt != 1) begin
                errors++;
                $display("FAIL rand_count: got %0d writes %0d done want %0d 1",
                         wr_addr_q.size(), done_cnt, exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    checks++;
                    if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                        errors++;
                        $display("FAIL rand_write%0d: got %h/%h want %h/%h", i, wr_addr_q[i],
                                 wr_data_q[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            checks++;
            if (err !== m_err || err_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL rand_err: got %b/%0d want %b/%0d", err, err_cnt, m_err, m_cnt);
            end
            $display("test_random load %0d: %0d writes, err_cnt %0d", n, wr_addr_q.size(), err_cnt);
        end
    endtask

    task automatic test_err_saturate();
        logic rdy;
        clear_log();
        start_load('h000, 1);
        repeat (260) send('h3F, 0, 0, 0, 0, 1'b1, rdy);
        checks++;
        if (err_cnt !== 8'(m_cnt) || m_cnt != 255) begin
            errors++; $display("FAIL sat_cnt: got %0d want %0d", err_cnt, m_cnt);
        end
        send('h0E, 1, 1, 1, 1, 1'b1, rdy);
        finish_load();
        checks++;
        if (err_cnt !== 8'd255 || wr_addr_q.size() != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL sat_end: got cnt %0d writes %0d want 255 1", err_cnt, wr_addr_q.size());
        end
        $display("test_err_saturate: err_cnt %0d", err_cnt);
    endtask

    task automatic test_reset_mid_run();
        logic rdy;
        clear_log();
        start_load('h040, 5);
        send('h03, 1, 1, 1, 1, 1'b1, rdy);
        send('h04, 2, 2, 2, 2, 1'b1, rdy);
        in_valid = 1'b1; in_opc = 6'h05; in_rd = 5'd0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, imem_we, busy, done, err} !== 5'b0 ||
            {imem_addr, imem_wdata, err_cnt} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: flags %b addr %h wdata %h want all 0",
                     {in_ready, imem_we, busy, done, err}, imem_addr, imem_wdata);
        end
        @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: got %0d writes busy %b want 0 0", wr_addr_q.size(), busy);
        end
        in_valid = 1'b0;
        start_load('h080, 1);
        send_rand(1'b1, rdy);
        finish_load();
        checks++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 'h080 || wr_data_q[0] !== exp_data[0]) begin
            errors++;
            $display("FAIL midrst_restart: got %0d writes want 1 at 080", wr_addr_q.size());
        end
        $display("test_reset_mid_run: restart wrote %0d", wr_addr_q.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_wrap();
        test_len_zero();
        test_abort();
        test_random();
        test_err_saturate();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
